// File: rtl/instruction_decode_unit_if.sv
// Decode-stage port bundle: fetch/writeback/hazard inputs and the ID/EX register outputs.
// No valid/ready handshake: ID/EX advances every clock, FlushE turns the next entry into a bubble.
interface instruction_decode_unit_if;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        FlushE;

    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic        ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [4:0]  RdE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic        IllegalE;

    modport master (
        output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        input  Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
               ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E, IllegalE
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        output Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
               ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E, IllegalE
    );
endinterface

// File: rtl/instruction_decode_unit.sv
// RV32I decode stage: control decode, 32x32 register file with write-first bypass,
// immediate generation and the flushable ID/EX pipeline register.
module instruction_decode_unit (
    input logic                      clk,
    input logic                      rst,
    instruction_decode_unit_if.slave bus
);
    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpIAlu = 7'b0010011;
    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpBeq  = 7'b1100011;
    localparam logic [6:0] OpJal  = 7'b1101111;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    logic        regWriteD, memWriteD, jumpD, branchD, aluSrcD, illegalD;
    logic [1:0]  immSrcD, resultSrcD, aluOpD;
    logic [2:0]  aluControlD;
    logic [31:0] immExtD, rd1D, rd2D;
    logic [31:0] regs [32];

    assign instr    = bus.InstrD;
    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign bus.Rs1D = rs1;
    assign bus.Rs2D = rs2;

    // Don't-care fields resolve to 0 (R-type ImmSrc, jal ALUSrc/ALUOp).
    always_comb begin
        regWriteD  = 1'b0;
        immSrcD    = 2'b00;
        aluSrcD    = 1'b0;
        memWriteD  = 1'b0;
        resultSrcD = 2'b00;
        branchD    = 1'b0;
        aluOpD     = 2'b00;
        jumpD      = 1'b0;
        illegalD   = 1'b0;
        case (opcode)
            OpR: begin
                regWriteD = 1'b1;
                aluOpD    = 2'b10;
            end
            OpIAlu: begin
                regWriteD = 1'b1;
                aluSrcD   = 1'b1;
                aluOpD    = 2'b10;
            end
            OpLw: begin
                regWriteD  = 1'b1;
                aluSrcD    = 1'b1;
                resultSrcD = 2'b01;
            end
            OpSw: begin
                immSrcD   = 2'b01;
                aluSrcD   = 1'b1;
                memWriteD = 1'b1;
            end
            OpBeq: begin
                immSrcD = 2'b10;
                branchD = 1'b1;
                aluOpD  = 2'b01;
            end
            OpJal: begin
                regWriteD  = 1'b1;
                immSrcD    = 2'b11;
                resultSrcD = 2'b10;
                jumpD      = 1'b1;
            end
            default: illegalD = (instr != 32'd0);
        endcase
    end

    always_comb begin
        aluControlD = 3'b000;
        case (aluOpD)
            2'b01: aluControlD = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  aluControlD = (opcode[5] & instr[30]) ? 3'b001 : 3'b000;
                    3'b010:  aluControlD = 3'b101;
                    3'b110:  aluControlD = 3'b011;
                    3'b111:  aluControlD = 3'b010;
                    default: aluControlD = 3'b000;
                endcase
            end
            default: aluControlD = 3'b000;
        endcase
    end

    always_comb begin
        immExtD = {{20{instr[31]}}, instr[31:20]};
        case (immSrcD)
            2'b01:   immExtD = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            2'b10:   immExtD = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            2'b11:   immExtD = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: immExtD = {{20{instr[31]}}, instr[31:20]};
        endcase
    end

    // Write-first bypass lets a writeback land in the same cycle's decode.
    always_comb begin
        rd1D = regs[rs1];
        if (rs1 == 5'd0)
            rd1D = 32'd0;
        else if (bus.RegWriteW && (bus.RDW == rs1))
            rd1D = bus.ResultW;
        rd2D = regs[rs2];
        if (rs2 == 5'd0)
            rd2D = 32'd0;
        else if (bus.RegWriteW && (bus.RDW == rs2))
            rd2D = bus.ResultW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'd0;
        end else if (bus.RegWriteW && (bus.RDW != 5'd0)) begin
            regs[bus.RDW] <= bus.ResultW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.FlushE) begin
            bus.RegWriteE   <= 1'b0;
            bus.MemWriteE   <= 1'b0;
            bus.JumpE       <= 1'b0;
            bus.BranchE     <= 1'b0;
            bus.ALUSrcE     <= 1'b0;
            bus.ResultSrcE  <= 2'b00;
            bus.ALUControlE <= 3'b000;
            bus.RD1E        <= 32'd0;
            bus.RD2E        <= 32'd0;
            bus.ImmExtE     <= 32'd0;
            bus.PCE         <= 32'd0;
            bus.PCPlus4E    <= 32'd0;
            bus.RdE         <= 5'd0;
            bus.Rs1E        <= 5'd0;
            bus.Rs2E        <= 5'd0;
            bus.IllegalE    <= 1'b0;
        end else begin
            bus.RegWriteE   <= regWriteD;
            bus.MemWriteE   <= memWriteD;
            bus.JumpE       <= jumpD;
            bus.BranchE     <= branchD;
            bus.ALUSrcE     <= aluSrcD;
            bus.ResultSrcE  <= resultSrcD;
            bus.ALUControlE <= aluControlD;
            bus.RD1E        <= rd1D;
            bus.RD2E        <= rd2D;
            bus.ImmExtE     <= immExtD;
            bus.PCE         <= bus.PCD;
            bus.PCPlus4E    <= bus.PCPlus4D;
            bus.RdE         <= instr[11:7];
            bus.Rs1E        <= rs1;
            bus.Rs2E        <= rs2;
            bus.IllegalE    <= illegalD;
        end
    end
endmodule

// File: tb/tb_instruction_decode_unit.sv
// Bench for instruction_decode_unit: directed cases plus random instruction streams
// compared against an instruction-level reference model of decode and the register file.
module tb_instruction_decode_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_decode_unit_if bus ();
    instruction_decode_unit dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic        regWrite, memWrite, jump, branch, aluSrc;
        logic [1:0]  resultSrc;
        logic [2:0]  aluControl;
        logic [31:0] rd1, rd2, immExt, pc, pcPlus4;
        logic [4:0]  rd, rs1, rs2;
        logic        illegal;
    } eOut_t;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] modelRegs [32];
    logic        pendRst, pendWen;
    logic [4:0]  pendRd;
    logic [31:0] pendData;
    eOut_t       expE, expMask;

    function automatic logic [31:0] readModel(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (pendWen && pendRd == idx) return pendData;
        return modelRegs[idx];
    endfunction

    function automatic logic [2:0] aluModel(input logic [2:0] f3, input logic isSub);
        case (f3)
            3'b000:  return isSub ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic eOut_t modelDecode(input logic [31:0] i, input logic [31:0] pc);
        eOut_t e = '0;
        e.pc = pc;
        e.pcPlus4 = pc + 32'd4;
        e.rd = i[11:7];
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.rd1 = readModel(i[19:15]);
        e.rd2 = readModel(i[24:20]);
        e.immExt = 32'($signed(i[31:20]));
        case (i[6:0])
            7'h33: begin e.regWrite = 1; e.aluControl = aluModel(i[14:12], i[30]); end
            7'h13: begin e.regWrite = 1; e.aluSrc = 1; e.aluControl = aluModel(i[14:12], 1'b0); end
            7'h03: begin e.regWrite = 1; e.aluSrc = 1; e.resultSrc = 2'd1; end
            7'h23: begin
                e.memWrite = 1; e.aluSrc = 1;
                e.immExt = 32'($signed({i[31:25], i[11:7]}));
            end
            7'h63: begin
                e.branch = 1; e.aluControl = 3'b001;
                e.immExt = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            end
            7'h6F: begin
                e.regWrite = 1; e.jump = 1; e.resultSrc = 2'd2;
                e.immExt = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            end
            default: e.illegal = (i != 32'd0);
        endcase
        return e;
    endfunction

    function automatic eOut_t careMask(input logic [31:0] i);
        eOut_t m = '1;
        if (i[6:0] == 7'h33) m.immExt = '0;
        if (i[6:0] == 7'h6F) begin m.aluSrc = 1'b0; m.aluControl = '0; end
        return m;
    endfunction

    function automatic eOut_t sampleE();
        eOut_t a;
        a.regWrite = bus.RegWriteE;   a.memWrite = bus.MemWriteE;
        a.jump = bus.JumpE;           a.branch = bus.BranchE;
        a.aluSrc = bus.ALUSrcE;       a.resultSrc = bus.ResultSrcE;
        a.aluControl = bus.ALUControlE;
        a.rd1 = bus.RD1E;             a.rd2 = bus.RD2E;
        a.immExt = bus.ImmExtE;       a.pc = bus.PCE;
        a.pcPlus4 = bus.PCPlus4E;     a.rd = bus.RdE;
        a.rs1 = bus.Rs1E;             a.rs2 = bus.Rs2E;
        a.illegal = bus.IllegalE;
        return a;
    endfunction

    task automatic setInputs(input logic [31:0] instr, input logic [31:0] pc, input logic wen,
                             input logic [4:0] rdw, input logic [31:0] res, input logic flush,
                             input logic r);
        bus.InstrD = instr;
        bus.PCD = pc;
        bus.PCPlus4D = pc + 32'd4;
        bus.RegWriteW = wen;
        bus.RDW = rdw;
        bus.ResultW = res;
        bus.FlushE = flush;
        rst = r;
        pendRst = r;
        pendWen = wen && (rdw != 5'd0);
        pendRd = rdw;
        pendData = res;
        expE = (r || flush) ? eOut_t'('0) : modelDecode(instr, pc);
        expMask = (r || flush) ? eOut_t'('1) : careMask(instr);
    endtask

    task automatic tick();
        @(posedge clk);
        if (pendRst) begin
            for (int k = 0; k < 32; k++) modelRegs[k] = 32'd0;
        end else if (pendWen) begin
            modelRegs[pendRd] = pendData;
        end
        #1;
    endtask

    task automatic test_reset();
        setInputs(32'h406283B3, 32'h40, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        tick();
        tick();
        checkCount++;
        if (sampleE() !== eOut_t'('0))
            $display("FAIL reset_outputs: got %h expected 0", sampleE());
        else passCount++;
        setInputs(32'h00028333, 32'h100, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkCount++;
        if (bus.RD1E !== 32'd0 || bus.RdE !== 5'd6)
            $display("FAIL reset_regfile: got RD1E=%h RdE=%0d expected RD1E=0 RdE=6", bus.RD1E, bus.RdE);
        else passCount++;
    endtask

    task automatic test_write_read();
        setInputs(32'd0, 32'h104, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        tick();
        setInputs(32'h00028333, 32'h108, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkCount++;
        if ({bus.RD1E, bus.RdE, bus.RegWriteE, bus.ALUControlE, bus.ALUSrcE} !==
            {32'hDEADBEEF, 5'd6, 1'b1, 3'b000, 1'b0})
            $display("FAIL write_read: got RD1E=%h RdE=%0d RegWriteE=%b ALUControlE=%b ALUSrcE=%b expected DEADBEEF/6/1/000/0",
                     bus.RD1E, bus.RdE, bus.RegWriteE, bus.ALUControlE, bus.ALUSrcE);
        else passCount++;
    endtask

    task automatic test_bypass_x0();
        setInputs(32'h406283B3, 32'h10C, 1'b1, 5'd5, 32'h12345678, 1'b0, 1'b0);
        tick();
        checkCount++;
        if ({bus.RD1E, bus.RD2E, bus.ALUControlE, bus.RdE} !== {32'h12345678, 32'd0, 3'b001, 5'd7})
            $display("FAIL bypass_sub: got RD1E=%h RD2E=%h ALUControlE=%b RdE=%0d expected 12345678/0/001/7",
                     bus.RD1E, bus.RD2E, bus.ALUControlE, bus.RdE);
        else passCount++;
        setInputs(32'h00000333, 32'h110, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        tick();
        checkCount++;
        if (bus.RD1E !== 32'd0)
            $display("FAIL x0_same_cycle: got RD1E=%h expected 0", bus.RD1E);
        else passCount++;
        setInputs(32'h00000333, 32'h114, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkCount++;
        if ({bus.RD1E, bus.RD2E} !== 64'd0)
            $display("FAIL x0_later: got RD1E=%h RD2E=%h expected 0/0", bus.RD1E, bus.RD2E);
        else passCount++;
        setInputs(32'h00028333, 32'h118, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkCount++;
        if (bus.RD1E !== 32'h12345678)
            $display("FAIL bypass_stored: got RD1E=%h expected 12345678", bus.RD1E);
        else passCount++;
    endtask

    task automatic test_immediates();
        setInputs(32'hFE208CE3, 32'h200, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkCount++;
        if ({bus.ImmExtE, bus.BranchE, bus.ALUControlE, bus.RegWriteE} !== {32'hFFFFFFF8, 1'b1, 3'b001, 1'b0})
            $display("FAIL imm_beq: got ImmExtE=%h BranchE=%b ALUControlE=%b RegWriteE=%b expected FFFFFFF8/1/001/0",
                     bus.ImmExtE, bus.BranchE, bus.ALUControlE, bus.RegWriteE);
        else passCount++;
        setInputs(32'hFE20AE23, 32'h204, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkCount++;
        if ({bus.ImmExtE, bus.MemWriteE, bus.ALUSrcE, bus.RegWriteE} !== {32'hFFFFFFFC, 1'b1, 1'b1, 1'b0})
            $display("FAIL imm_sw: got ImmExtE=%h MemWriteE=%b ALUSrcE=%b RegWriteE=%b expected FFFFFFFC/1/1/0",
                     bus.ImmExtE, bus.MemWriteE, bus.ALUSrcE, bus.RegWriteE);
        else passCount++;
    endtask

    task automatic test_flush_illegal();
        setInputs(32'h0002A303, 32'h300, 1'b1, 5'd9, 32'hCAFE0009, 1'b1, 1'b0);
        tick();
        checkCount++;
        if (sampleE() !== eOut_t'('0))
            $display("FAIL flush_lw: got %h expected 0", sampleE());
        else passCount++;
        setInputs(32'h00048333, 32'h304, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkCount++;
        if (bus.RD1E !== 32'hCAFE0009)
            $display("FAIL flush_write_commits: got RD1E=%h expected CAFE0009", bus.RD1E);
        else passCount++;
        setInputs(32'h0000007F, 32'h308, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkCount++;
        if ({bus.IllegalE, bus.RegWriteE, bus.MemWriteE} !== 3'b100)
            $display("FAIL illegal_op: got IllegalE=%b RegWriteE=%b MemWriteE=%b expected 1/0/0",
                     bus.IllegalE, bus.RegWriteE, bus.MemWriteE);
        else passCount++;
        setInputs(32'd0, 32'h30C, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkCount++;
        if (bus.IllegalE !== 1'b0 || bus.RegWriteE !== 1'b0)
            $display("FAIL zero_bubble: got IllegalE=%b RegWriteE=%b expected 0/0", bus.IllegalE, bus.RegWriteE);
        else passCount++;
    endtask

    task automatic test_random();
        logic [6:0]  badOps [5] = '{7'h7F, 7'h37, 7'h17, 7'h67, 7'h73};
        logic [31:0] i, pc;
        logic        r, f, wen;
        for (int n = 0; n < 500; n++) begin
            i = $urandom;
            i[19:15] = 5'($urandom_range(0, 7));
            i[24:20] = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: begin i[6:0] = 7'h33; i[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
                1: i[6:0] = 7'h13;
                2: i[6:0] = 7'h03;
                3: i[6:0] = 7'h23;
                4: i[6:0] = 7'h63;
                5: i[6:0] = 7'h6F;
                6: i = 32'd0;
                default: i[6:0] = badOps[$urandom_range(0, 4)];
            endcase
            r = ($urandom_range(0, 49) == 0);
            f = ($urandom_range(0, 7) == 0);
            wen = 1'($urandom_range(0, 1));
            pc = $urandom & 32'hFFFFFFFC;
            setInputs(i, pc, wen, 5'($urandom_range(0, 7)), $urandom, f, r);
            #1;
            checkCount++;
            if ({bus.Rs1D, bus.Rs2D} !== {i[19:15], i[24:20]})
                $display("FAIL rand_rs_comb: got %h/%h expected %h/%h", bus.Rs1D, bus.Rs2D, i[19:15], i[24:20]);
            else passCount++;
            tick();
            checkCount++;
            if ((sampleE() & expMask) !== (expE & expMask))
                $display("FAIL rand_decode n=%0d instr=%h: got %h expected %h", n, i, sampleE() & expMask, expE & expMask);
            else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass_x0();
        test_immediates();
        test_flush_illegal();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
